// File: rtl/plru4_set_ctrl_if.sv
// Request / response / PLRU-engine / fill-port signal bundle for plru4_set_ctrl.
// Handshakes: a transfer on req or fill happens on a rising clock edge where
// valid and ready are both high; valid-side payload stays stable until then.
// rsp_valid, plru_miss_req, plru_access_valid and fill_done are single-cycle
// pulses with no back-pressure.
interface plru4_set_ctrl_if #(
  parameter int TAG_W = 20
);
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [1:0]       rsp_way;
  logic             rsp_err;
  logic             plru_access_valid;
  logic [1:0]       plru_access_way;
  logic             plru_miss_req;
  logic [1:0]       plru_victim_way;
  logic             fill_valid;
  logic             fill_ready;
  logic [TAG_W-1:0] fill_tag;
  logic [1:0]       fill_way;
  logic             fill_done;

  // Controller side.
  modport slave (
    input  req_valid, req_tag, plru_victim_way, fill_ready, fill_done,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_err,
           plru_access_valid, plru_access_way, plru_miss_req,
           fill_valid, fill_tag, fill_way
  );

  // Environment side (requester, PLRU engine, backing store).
  modport master (
    output req_valid, req_tag, plru_victim_way, fill_ready, fill_done,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_err,
           plru_access_valid, plru_access_way, plru_miss_req,
           fill_valid, fill_tag, fill_way
  );
endinterface

// File: rtl/plru4_set_ctrl.sv
// plru4_set_ctrl: controller for one 4-way set of the tag cache.
// Looks up a tag, fills invalid ways first, otherwise asks the tree-PLRU
// engine for a victim, fetches the line and reports every access back to the
// engine. Optional hit/miss/evict counters are enabled by PLRU4_STATS_EN.
module plru4_set_ctrl #(
  parameter int TAG_W        = 20,
  parameter int FILL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  plru4_set_ctrl_if.slave bus,
  output logic [2:0]  o_dbg_state
`ifdef PLRU4_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_evicts
`endif
);

  localparam int CNT_W = (FILL_TIMEOUT > 0) ? $clog2(FILL_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (FILL_TIMEOUT > 0) ? CNT_W'(FILL_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_VREQ, S_VWAIT, S_FILL, S_WAIT, S_INSTALL, S_RESP
  } state_t;

  state_t           r_state, w_next;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_tags [4];
  logic [3:0]       r_valid;
  logic [1:0]       r_way;
  logic             r_hit;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_match;
  logic             w_any_match;
  logic [1:0]       w_match_way;
  logic             w_any_inv;
  logic [1:0]       w_inv_way;
  logic             w_timeout;

  // Tag compare and lowest-index priority pick for matching / invalid ways.
  always_comb begin
    w_match     = '0;
    w_any_match = 1'b0;
    w_match_way = '0;
    w_any_inv   = 1'b0;
    w_inv_way   = '0;
    for (int i = 3; i >= 0; i--) begin
      w_match[i] = r_valid[i] && (r_tags[i] == r_tag);
      if (w_match[i]) begin
        w_any_match = 1'b1;
        w_match_way = 2'(i);
      end
      if (!r_valid[i]) begin
        w_any_inv = 1'b1;
        w_inv_way = 2'(i);
      end
    end
  end

  // The WAIT state spends FILL_TIMEOUT cycles before giving up on the fill.
  assign w_timeout = (FILL_TIMEOUT != 0) && (r_cnt == TO_LAST) && !bus.fill_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.req_valid) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_any_match)    w_next = S_RESP;
        else if (w_any_inv) w_next = S_FILL;
        else                w_next = S_VREQ;
      end
      S_VREQ:    w_next = S_VWAIT;
      S_VWAIT:   w_next = S_FILL;
      S_FILL:    if (bus.fill_ready) w_next = S_WAIT;
      S_WAIT: begin
        if (bus.fill_done)  w_next = S_INSTALL;
        else if (w_timeout) w_next = S_RESP;
      end
      S_INSTALL: w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Request latch, destination way, timeout counter and tag array updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag   <= '0;
      r_valid <= '0;
      r_way   <= '0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < 4; i++) r_tags[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_tag <= bus.req_tag;
            r_hit <= 1'b0;
            r_err <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (w_any_match) begin
            r_hit <= 1'b1;
            r_way <= w_match_way;
          end else if (w_any_inv) begin
            r_way <= w_inv_way;
          end
        end
        S_VWAIT: r_way <= bus.plru_victim_way;
        S_FILL:  if (bus.fill_ready) r_cnt <= '0;
        S_WAIT: begin
          if (w_timeout)          r_err <= 1'b1;
          else if (!bus.fill_done) r_cnt <= r_cnt + 1'b1;
        end
        S_INSTALL: begin
          r_tags[r_way]  <= r_tag;
          r_valid[r_way] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset clears them without a clock edge.
  always_comb begin
    bus.req_ready         = (r_state == S_IDLE);
    bus.rsp_valid         = (r_state == S_RESP);
    bus.rsp_hit           = (r_state == S_RESP) && r_hit;
    bus.rsp_way           = (r_state == S_RESP) ? r_way : 2'd0;
    bus.rsp_err           = (r_state == S_RESP) && r_err;
    bus.plru_access_valid = (r_state == S_RESP) && !r_err;
    bus.plru_access_way   = ((r_state == S_RESP) && !r_err) ? r_way : 2'd0;
    bus.plru_miss_req     = (r_state == S_VREQ);
    bus.fill_valid        = (r_state == S_FILL);
    bus.fill_tag          = (r_state == S_FILL) ? r_tag : '0;
    bus.fill_way          = (r_state == S_FILL) ? r_way : 2'd0;
    o_dbg_state           = r_state;
  end

`ifdef PLRU4_STATS_EN
  logic [31:0] r_stat_hits, r_stat_misses, r_stat_evicts;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_evicts <= '0;
    end else begin
      if ((r_state == S_RESP) && r_hit && (r_stat_hits != '1))
        r_stat_hits <= r_stat_hits + 32'd1;
      if ((r_state == S_LOOKUP) && !w_any_match && (r_stat_misses != '1))
        r_stat_misses <= r_stat_misses + 32'd1;
      if ((r_state == S_VWAIT) && (r_stat_evicts != '1))
        r_stat_evicts <= r_stat_evicts + 32'd1;
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_evicts = r_stat_evicts;
`endif

endmodule

// File: tb/tb_plru4_set_ctrl.sv
// Bench for plru4_set_ctrl: directed scenarios plus randomized requests,
// checked against a set-content model (valid/tag per way) in the bench.
module tb_plru4_set_ctrl;
  localparam int TAG_W = 20;
  localparam int TO    = 8;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
`ifdef PLRU4_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_evicts;
`endif

  plru4_set_ctrl_if #(.TAG_W(TAG_W)) bus ();

  plru4_set_ctrl #(.TAG_W(TAG_W), .FILL_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef PLRU4_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_evicts (stat_evicts)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0]       exp_q [$];   // {hit, err, way}
  logic             m_valid [4];
  logic [TAG_W-1:0] m_tag   [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  // ---------------- driver: one full request ----------------
  task automatic run_req(input logic [TAG_W-1:0] tag, input int rdy_delay,
                         input bit do_done, input int done_delay,
                         input logic [1:0] victim);
    bit         exp_hit, exp_err, exp_mreq, got, hs_done, stable_ok, waited;
    logic [1:0] exp_way, r_way, f_way, acc_way;
    logic       r_hit, r_err, acc;
    logic [TAG_W-1:0] f_tag;
    logic [3:0] exp_ent;
    int         fv_cnt, since_hs, mreq_cnt, overlap, rsp_c, exp_lat;

    // Expected outcome from the set contents.
    exp_hit = 0; exp_way = 0; exp_mreq = 0;
    for (int i = 0; i < 4; i++)
      if (!exp_hit && m_valid[i] && m_tag[i] == tag) begin
        exp_hit = 1; exp_way = 2'(i);
      end
    if (!exp_hit) begin
      exp_mreq = 1;
      for (int i = 3; i >= 0; i--)
        if (!m_valid[i]) begin exp_way = 2'(i); exp_mreq = 0; end
      if (exp_mreq) exp_way = victim;
    end
    exp_err = !exp_hit && !do_done;
    exp_q.push_back({exp_hit, exp_err, exp_way});
    if (exp_hit)      exp_lat = 2;
    else if (exp_err) exp_lat = rdy_delay + 11 + (exp_mreq ? 2 : 0);
    else              exp_lat = rdy_delay + done_delay + 5 + (exp_mreq ? 2 : 0);

    // Wait for the controller to be idle, then present the request.
    waited = 0;
    for (int c = 0; c < 50 && !waited; c++) begin
      @(negedge clk);
      if (bus.req_ready) waited = 1;
    end
    check("req_ready_before_req", 32'(waited), 1);
    if (!waited) begin
      void'(exp_q.pop_back());
      return;
    end
    bus.req_valid       = 1'b1;
    bus.req_tag         = tag;
    bus.plru_victim_way = victim;
    @(posedge clk);

    got = 0; hs_done = 0; stable_ok = 1; fv_cnt = 0; since_hs = 0;
    mreq_cnt = 0; overlap = 0; rsp_c = 0;
    r_hit = 0; r_err = 0; r_way = 0; acc = 0; acc_way = 0; f_tag = '0; f_way = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.fill_done = 1'b0;
      if (c == 1) check("req_ready_drops", 32'(bus.req_ready), 0);
      if (bus.plru_miss_req) mreq_cnt++;
      if (bus.plru_miss_req && bus.plru_access_valid) overlap++;
      if (bus.rsp_valid) begin
        got = 1; rsp_c = c;
        r_hit = bus.rsp_hit; r_err = bus.rsp_err; r_way = bus.rsp_way;
        acc = bus.plru_access_valid; acc_way = bus.plru_access_way;
      end else if (bus.fill_valid) begin
        if (fv_cnt == 0) begin
          f_tag = bus.fill_tag; f_way = bus.fill_way;
        end else if (bus.fill_tag !== f_tag || bus.fill_way !== f_way) begin
          stable_ok = 0;
        end
        fv_cnt++;
        bus.fill_ready = (fv_cnt > rdy_delay);
        if (bus.fill_ready) hs_done = 1;
      end else begin
        bus.fill_ready = 1'b0;
        if (hs_done) begin
          since_hs++;
          if (do_done && since_hs == done_delay + 1) bus.fill_done = 1'b1;
        end
      end
    end
    bus.fill_ready = 1'b0;
    bus.fill_done  = 1'b0;

    check("rsp_seen", 32'(got), 1);
    if (!got) begin
      void'(exp_q.pop_front());
      return;
    end
    exp_ent = exp_q.pop_front();
    check("rsp_fields", {28'd0, r_hit, r_err, r_way}, {28'd0, exp_ent});
    check("rsp_latency", 32'(rsp_c), 32'(exp_lat));
    check("access_valid", 32'(acc), 32'(!exp_err));
    if (!exp_err) check("access_way", 32'(acc_way), 32'(exp_way));
    check("miss_req_count", 32'(mreq_cnt), 32'(exp_mreq));
    check("miss_access_overlap", 32'(overlap), 0);
    check("fill_issued", 32'(fv_cnt > 0), 32'(!exp_hit));
    if (!exp_hit) begin
      check("fill_tag", 32'(f_tag), 32'(tag));
      check("fill_way", 32'(f_way), 32'(exp_way));
      check("fill_stable", 32'(stable_ok), 1);
      check("fill_wait_cycles", 32'(fv_cnt), 32'(rdy_delay + 1));
    end

    // Install into the model only on a completed fill.
    if (!exp_hit && !exp_err) begin
      m_valid[exp_way] = 1'b1;
      m_tag[exp_way]   = tag;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [TAG_W-1:0] pool [6];
  bit               seen;

  initial begin
    pool = '{20'h00011, 20'h00022, 20'h00033, 20'h00044, 20'h00055, 20'h00066};
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_tag = '0; bus.plru_victim_way = 2'd0;
    bus.fill_ready = 1'b0; bus.fill_done = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_fill_valid", 32'(bus.fill_valid), 0);
    check("rst_miss_req", 32'(bus.plru_miss_req), 0);
    check("rst_access_valid", 32'(bus.plru_access_valid), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // Cold and invalid-first fills.
    run_req(20'h00011, 0, 1, 0, 2'd3);
    run_req(20'h00022, 1, 1, 2, 2'd3);
    run_req(20'h00033, 0, 1, 1, 2'd3);
    run_req(20'h00044, 2, 1, 0, 2'd3);
    // Hit path.
    run_req(20'h00022, 0, 1, 0, 2'd0);
    // PLRU eviction into way 2, then old tag misses and new tag hits.
    run_req(20'h00055, 0, 1, 0, 2'd2);
    run_req(20'h00033, 0, 1, 0, 2'd0);
    run_req(20'h00055, 0, 1, 0, 2'd1);
    // Fill back-pressure for 10 cycles.
    run_req(20'h00066, 10, 1, 1, 2'd1);
    // Fill timeout: no install, way 3 keeps its tag.
    run_req(20'h00077, 0, 0, 0, 2'd3);
    run_req(20'h00044, 0, 1, 0, 2'd0);

    // Stray fill_done while idle is ignored.
    @(negedge clk); bus.fill_done = 1'b1;
    @(negedge clk); bus.fill_done = 1'b0;
    check("stray_done_idle", 32'(dbg_state), 0);
    check("stray_done_ready", 32'(bus.req_ready), 1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++)
      run_req(pool[$urandom_range(0, 5)], $urandom_range(0, 3),
              ($urandom_range(0, 7) != 0), $urandom_range(0, 3),
              2'($urandom_range(0, 3)));

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_tag = 20'h00099; bus.plru_victim_way = 2'd1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.fill_valid) begin
        seen = 1;
        bus.fill_ready = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("reset_test_fill_seen", 32'(seen), 1);
    @(negedge clk); bus.fill_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_in_wait", 32'(dbg_state), 3'd5);
    #2 rst = 1'b1;
    #1;
    check("async_req_ready", 32'(bus.req_ready), 1);
    check("async_fill_valid", 32'(bus.fill_valid), 0);
    check("async_rsp_valid", 32'(bus.rsp_valid), 0);
    check("async_miss_req", 32'(bus.plru_miss_req), 0);
    check("async_access_valid", 32'(bus.plru_access_valid), 0);
    check("async_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run_req(20'h00011, 0, 1, 0, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
